// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with optional return-address stack.
// Ops: 00 INC, 01 JUMP, 10 CALL, 11 RET, executed on the rising Clk edge
// when Enable is high. Rst is synchronous and active-high.
// Build option: define PC_SEQUENCER_RETURN_STACK_EN to build the return
// stack. Without it, CALL behaves as JUMP, RET behaves as INC, and the
// stack status outputs are tied off.
module pc_sequencer #(
  parameter int                        ADDRESS_LENGTH = 16,
  parameter int                        STACK_DEPTH    = 8,
  parameter logic [ADDRESS_LENGTH-1:0] RESET_VECTOR   = '0,
  parameter int                        PC_STEP        = 1
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic                               Enable,
  input  logic [1:0]                         Op,
  input  logic [ADDRESS_LENGTH-1:0]          PCWriteAddr,
  output logic [ADDRESS_LENGTH-1:0]          PCReadAddr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   StackDepth,
  output logic                               StackFull,
  output logic                               StackEmpty,
  output logic                               Fault
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int AW = $clog2(STACK_DEPTH);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  // Step is truncated to the PC width so the add wraps silently.
  localparam logic [ADDRESS_LENGTH-1:0] STEP = ADDRESS_LENGTH'(PC_STEP);

  logic [ADDRESS_LENGTH-1:0] pc_q, pc_d;
  logic [ADDRESS_LENGTH-1:0] pc_inc;

  assign pc_inc     = pc_q + STEP;
  assign PCReadAddr = pc_q;

`ifdef PC_SEQUENCER_RETURN_STACK_EN

  // Entry contents are not reset: depth_q alone decides what is readable.
  logic [ADDRESS_LENGTH-1:0] stack_q [STACK_DEPTH];
  logic [DW-1:0]             depth_q, depth_d;
  logic                      fault_q, fault_d;
  logic                      push;
  logic                      full, empty;
  logic [AW-1:0]             wr_idx, top_idx;

  assign full    = (depth_q == DW'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - DW'(1));

  // Next-state decode; overflow/underflow hold PC and stack, only raise Fault.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    fault_d = fault_q;
    push    = 1'b0;
    if (Enable) begin
      case (Op)
        OP_INC:  pc_d = pc_inc;
        OP_JUMP: pc_d = PCWriteAddr;
        OP_CALL: begin
          if (full) begin
            fault_d = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = PCWriteAddr;
            depth_d = depth_q + DW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = stack_q[top_idx];
            depth_d = depth_q - DW'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // PC, depth and sticky fault registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // Return-address write: push the sequential successor of the calling PC.
  always_ff @(posedge Clk) begin
    if (push && !Rst) stack_q[wr_idx] <= pc_inc;
  end

  assign StackDepth = depth_q;
  assign StackFull  = full;
  assign StackEmpty = empty;
  assign Fault      = fault_q;

`else

  // Next-state decode without a stack: CALL jumps, RET advances.
  always_comb begin
    pc_d = pc_q;
    if (Enable) begin
      case (Op)
        OP_INC:  pc_d = pc_inc;
        OP_JUMP: pc_d = PCWriteAddr;
        OP_CALL: pc_d = PCWriteAddr;
        OP_RET:  pc_d = pc_inc;
        default: pc_d = pc_q;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge Clk) begin
    if (Rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  assign StackDepth = '0;
  assign StackFull  = 1'b0;
  assign StackEmpty = 1'b1;
  assign Fault      = 1'b0;

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer at default parameters; expected values
// follow whichever build option (return stack on/off) is compiled.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RETURN_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [1:0] INC = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic        Clk = 1'b0;
  logic        Rst, Enable;
  logic [1:0]  Op;
  logic [15:0] PCWriteAddr, PCReadAddr;
  logic [3:0]  StackDepth;
  logic        StackFull, StackEmpty, Fault;

  int npass = 0;
  int ntot  = 0;

  pc_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Op(Op), .PCWriteAddr(PCWriteAddr),
    .PCReadAddr(PCReadAddr), .StackDepth(StackDepth), .StackFull(StackFull),
    .StackEmpty(StackEmpty), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply one set of inputs across one rising edge, then settle 1 time unit.
  task automatic step(input logic rst, input logic en, input logic [1:0] op,
                      input logic [15:0] a);
    Rst = rst; Enable = en; Op = op; PCWriteAddr = a;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; Enable = 1'b0; Op = INC; PCWriteAddr = '0;
    #1;

    // Reset state
    step(1, 0, INC, 16'h0);
    chk("rst_pc",    PCReadAddr, 16'h0000);
    chk("rst_depth", StackDepth, 0);
    chk("rst_empty", StackEmpty, 1);
    chk("rst_full",  StackFull,  0);
    chk("rst_fault", Fault,      0);

    // Sequential advance 0 -> 1 -> 2 -> 3
    step(0, 1, INC, 16'h0); chk("inc1", PCReadAddr, 16'h0001);
    step(0, 1, INC, 16'h0); chk("inc2", PCReadAddr, 16'h0002);
    step(0, 1, INC, 16'h0); chk("inc3", PCReadAddr, 16'h0003);
    chk("inc_fault", Fault, 0);

    // Silent wrap at all-ones
    step(0, 1, JMP, 16'hFFFF); chk("jmp_ffff", PCReadAddr, 16'hFFFF);
    step(0, 1, INC, 16'h0);    chk("wrap_pc", PCReadAddr, 16'h0000);
    chk("wrap_fault", Fault, 0);

    // Nested call / return
    step(0, 1, JMP, 16'h0010);  chk("jmp_10", PCReadAddr, 16'h0010);
    step(0, 1, CALL, 16'h0100); chk("call1_pc", PCReadAddr, 16'h0100);
    chk("call1_depth", StackDepth, STK ? 1 : 0);
    step(0, 1, CALL, 16'h0200); chk("call2_pc", PCReadAddr, 16'h0200);
    chk("call2_depth", StackDepth, STK ? 2 : 0);
    step(0, 1, RET, 16'h0);     chk("ret1_pc", PCReadAddr, STK ? 16'h0101 : 16'h0201);
    chk("ret1_depth", StackDepth, STK ? 1 : 0);
    step(0, 1, RET, 16'h0);     chk("ret2_pc", PCReadAddr, STK ? 16'h0011 : 16'h0202);
    chk("ret2_depth", StackDepth, 0);
    chk("ret2_empty", StackEmpty, 1);

    // Fill the stack: calls to 0x1000,0x1010..0x1070; 8th push is 0x1061
    for (int i = 0; i < 8; i++) step(0, 1, CALL, 16'(16'h1000 + i * 16'h10));
    chk("fill_pc",    PCReadAddr, 16'h1070);
    chk("fill_depth", StackDepth, STK ? 8 : 0);
    chk("fill_full",  StackFull,  STK ? 1 : 0);
    chk("fill_fault", Fault, 0);
    step(0, 1, CALL, 16'h0ABC);
    chk("ovf_pc",    PCReadAddr, STK ? 16'h1070 : 16'h0ABC);
    chk("ovf_full",  StackFull,  STK ? 1 : 0);
    chk("ovf_fault", Fault,      STK ? 1 : 0);
    step(0, 1, RET, 16'h0);
    chk("ovf_ret_pc",    PCReadAddr, STK ? 16'h1061 : 16'h0ABD);
    chk("ovf_ret_depth", StackDepth, STK ? 7 : 0);
    chk("ovf_ret_fault", Fault,      STK ? 1 : 0);
    step(0, 1, RET, 16'h0);
    chk("lifo_pc", PCReadAddr, STK ? 16'h1051 : 16'h0ABE);

    // Underflow right after reset, then a JUMP with sticky fault
    step(1, 1, INC, 16'h0);
    chk("rst2_fault", Fault, 0);
    chk("rst2_depth", StackDepth, 0);
    step(0, 1, RET, 16'h0);
    chk("unf_pc",    PCReadAddr, STK ? 16'h0000 : 16'h0001);
    chk("unf_fault", Fault,      STK ? 1 : 0);
    step(0, 1, JMP, 16'h0040);
    chk("unf_jmp_pc",    PCReadAddr, 16'h0040);
    chk("unf_jmp_fault", Fault,      STK ? 1 : 0);

    // Enable low ignores the op
    step(0, 0, JMP, 16'h1234);
    chk("hold_pc",    PCReadAddr, 16'h0040);
    chk("hold_fault", Fault,      STK ? 1 : 0);
    step(0, 1, CALL, 16'h0300);
    chk("pre_rst_depth", StackDepth, STK ? 1 : 0);
    step(0, 0, RET, 16'h0);
    chk("hold_ret_pc",    PCReadAddr, 16'h0300);
    chk("hold_ret_depth", StackDepth, STK ? 1 : 0);

    // Reset wins over an enabled CALL and discards the stack
    step(1, 1, CALL, 16'h0555);
    chk("rstcall_pc",    PCReadAddr, 16'h0000);
    chk("rstcall_depth", StackDepth, 0);
    chk("rstcall_empty", StackEmpty, 1);
    chk("rstcall_fault", Fault, 0);
    step(0, 1, RET, 16'h0);
    chk("post_rst_ret_pc",    PCReadAddr, STK ? 16'h0000 : 16'h0001);
    chk("post_rst_ret_fault", Fault,      STK ? 1 : 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
